// File: rtl/avmm_bridge_pkg.sv
// Shared types and helpers for the Avalon-MM timeout bridge.
`timescale 1ns/1ps
package avmm_bridge_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/avmm_stall_timer.sv
// Counts consecutive stall cycles; expire pulses on the cycle the count
// would reach TIMEOUT, and the count restarts from zero.
`timescale 1ns/1ps
module avmm_stall_timer
  import avmm_bridge_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic expire
);

  localparam int CW = clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  assign expire = inc && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)              cnt <= '0;
    else if (clr || expire)  cnt <= '0;
    else if (inc)            cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/avmm_timeout_bridge.sv
// Avalon-MM pass-through that aborts stalled downstream traffic: on timeout
// it answers every outstanding read with ERR_DATA and drops the late replies.
`timescale 1ns/1ps
module avmm_timeout_bridge
  import avmm_bridge_pkg::*;
#(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4,
  parameter int TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic                clk_clk,
  input  logic                rst_clk_reset_n,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [DATA_W-1:0]   s_writedata,
  input  logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  input  logic                err_clear,
  output logic                err_irq,
  output logic [7:0]          err_count
);

  localparam int PW = clog2(MAX_PEND + 1);

  state_t        state, state_nx;
  logic [PW-1:0] pend, pend_nx, drop, drop_nx;
  logic          run, blocked, acc, fwd, stall_inc, expire;

  assign run     = (state == RUN);
  // Late replies from an aborted burst must drain before new traffic goes out.
  assign blocked = (s_read && pend == PW'(MAX_PEND)) || (drop != '0);

  assign m_address     = s_address;
  assign m_writedata   = s_writedata;
  assign m_byteenable  = s_byteenable;
  assign m_read        = run && s_read  && !blocked;
  assign m_write       = run && s_write && !blocked;
  assign s_waitrequest = !run || blocked || m_waitrequest;

  assign acc       = m_read && !m_waitrequest;
  assign fwd       = run && m_readdatavalid && (drop == '0);
  assign stall_inc = run && (((m_read || m_write) && m_waitrequest) ||
                             (pend != '0 && !m_readdatavalid));

  avmm_stall_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk_clk),
    .rst_n  (rst_clk_reset_n),
    .inc    (stall_inc),
    .clr    (!stall_inc),
    .expire (expire)
  );

  always_comb begin
    state_nx        = state;
    pend_nx         = pend;
    drop_nx         = drop;
    s_readdatavalid = 1'b0;
    s_readdata      = '0;
    if (m_readdatavalid && drop != '0) drop_nx = drop - 1'b1;
    case (state)
      RUN: begin
        if (acc && !fwd)      pend_nx = pend + 1'b1;
        else if (!acc && fwd) pend_nx = pend - 1'b1;
        if (fwd) begin
          s_readdatavalid = 1'b1;
          s_readdata      = m_readdata;
        end
        // A read accepted in the expiring cycle is owed an error reply too.
        if (expire) begin
          state_nx = FLUSH;
          drop_nx  = pend_nx;
        end
      end
      FLUSH: begin
        if (pend != '0) begin
          pend_nx         = pend - 1'b1;
          s_readdatavalid = 1'b1;
          s_readdata      = ERR_DATA;
        end
        if (pend <= PW'(1)) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
    if (!rst_clk_reset_n) begin
      s_readdatavalid = 1'b0;
      s_readdata      = '0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!rst_clk_reset_n) begin
      state     <= RUN;
      pend      <= '0;
      drop      <= '0;
      err_irq   <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
      drop  <= drop_nx;
      if (expire)         err_irq <= 1'b1;
      else if (err_clear) err_irq <= 1'b0;
      if (expire && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule
